// File: rtl/router_merge_pkg.sv
// router_merge_pkg: shared encodings and defaults for the two-input packet merge router
package router_merge_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_MAXLEN = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD0 = 2'd1,
        FWD1 = 2'd2
    } state_t;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

    // Forwarding state that serves the given source input
    function automatic state_t fwd_of(logic src);
        return src ? FWD1 : FWD0;
    endfunction

endpackage

// File: rtl/router_merge_if.sv
// router_merge_if: grant, two input flit channels, merged output channel and length error flag
interface router_merge_if #(parameter int WIDTH = router_merge_pkg::DEF_WIDTH);

    logic             win_valid;
    logic             win_ready;
    logic             win_data;
    logic             in0_valid;
    logic             in0_ready;
    logic [WIDTH-1:0] in0_data;
    logic             in0_last;
    logic             in1_valid;
    logic             in1_ready;
    logic [WIDTH-1:0] in1_data;
    logic             in1_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_src;
    logic             len_err;

    modport master (
        output win_valid, win_data,
        output in0_valid, in0_data, in0_last,
        output in1_valid, in1_data, in1_last,
        output out_ready,
        input  win_ready, in0_ready, in1_ready,
        input  out_valid, out_data, out_last, out_src, len_err
    );

    modport slave (
        input  win_valid, win_data,
        input  in0_valid, in0_data, in0_last,
        input  in1_valid, in1_data, in1_last,
        input  out_ready,
        output win_ready, in0_ready, in1_ready,
        output out_valid, out_data, out_last, out_src, len_err
    );

endinterface

// File: rtl/router_outreg.sv
// router_outreg: single-entry valid/ready output register that can reload while draining
module router_outreg
    import router_merge_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_src
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;
    logic             src_q, src_d;
    logic             load;

    // Accept when empty or when the held flit leaves at this edge
    always_comb begin
        in_ready = !valid_q || out_ready;
        load     = in_valid && in_ready;
        valid_d  = load || (valid_q && !out_ready);
        data_d   = load ? in_data : data_q;
        last_d   = load ? in_last : last_q;
        src_d    = load ? in_src : src_q;
    end

    // Register with asynchronous clear of contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            src_q   <= SRC0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            src_q   <= src_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign out_src   = src_q;

endmodule

// File: rtl/router_merge.sv
// router_merge: forwards whole packets from the granted input onto one output channel
module router_merge
    import router_merge_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int MAXLEN = DEF_MAXLEN
) (
    input  logic           clk,
    input  logic           rst_n,
    router_merge_if.slave  bus
);

    localparam int            CW      = $clog2(MAXLEN + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAXLEN);
    localparam logic [CW-1:0] CNT_ERR = CW'(MAXLEN - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             len_err_q, len_err_d;
    logic             sel_valid, sel_last, sel_src;
    logic [WIDTH-1:0] sel_data;
    logic             acc_ok, accept, tail;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A grant is taken in IDLE or at a tail, so a queued token skips the IDLE bubble
    always_comb begin
        state_d = state_q;
        if (bus.win_valid && bus.win_ready) state_d = fwd_of(bus.win_data);
        else if (tail)                      state_d = IDLE;
    end

    // Steer the granted input into the output register; the other input stays blocked
    always_comb begin
        sel_valid     = (state_q == FWD0 && bus.in0_valid) || (state_q == FWD1 && bus.in1_valid);
        sel_src       = (state_q == FWD1) ? SRC1 : SRC0;
        sel_data      = sel_src ? bus.in1_data : bus.in0_data;
        sel_last      = sel_src ? bus.in1_last : bus.in0_last;
        accept        = sel_valid && acc_ok;
        tail          = accept && sel_last;
        bus.in0_ready = (state_q == FWD0) && acc_ok;
        bus.in1_ready = (state_q == FWD1) && acc_ok;
        bus.win_ready = (state_q == IDLE) || tail;
        bus.len_err   = len_err_q;
    end

    // Saturating per-packet flit count; flag a packet about to exceed MAXLEN
    always_comb begin
        cnt_d     = tail ? '0 : (accept && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
        len_err_d = len_err_q || (accept && !sel_last && cnt_q == CNT_ERR);
    end

    // Counter and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
        end
    end

    router_outreg #(.WIDTH(WIDTH)) u_outreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (sel_valid),
        .in_ready  (acc_ok),
        .in_data   (sel_data),
        .in_last   (sel_last),
        .in_src    (sel_src),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (bus.out_data),
        .out_last  (bus.out_last),
        .out_src   (bus.out_src)
    );

endmodule

// File: tb/tb_router_merge.sv
// tb_router_merge: directed scoreboard bench for router_merge
module tb_router_merge;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    router_merge_if #(.WIDTH(8)) bus ();

    router_merge #(.WIDTH(8), .MAXLEN(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    int         n0    = 0;
    logic       blk0  = 1'b0;
    logic       lenchk = 1'b0;
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic       wq[$];
    logic [9:0] sb[$];
    int         out_cyc[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        bus.in0_valid = q0.size() > 0;
        {bus.in0_last, bus.in0_data} = q0.size() > 0 ? q0[0] : 9'h0;
        bus.in1_valid = q1.size() > 0;
        {bus.in1_last, bus.in1_data} = q1.size() > 0 ? q1[0] : 9'h0;
        bus.win_valid = wq.size() > 0;
        bus.win_data  = wq.size() > 0 ? wq[0] : 1'b0;
    endtask

    task automatic add(input logic src, input logic last, input logic [7:0] d);
        if (src) q1.push_back({last, d});
        else     q0.push_back({last, d});
        sb.push_back({src, last, d});
    endtask

    task automatic tick();
        logic       f0, f1, fw;
        logic [9:0] got, exp;
        @(negedge clk);
        cyc++;
        if (bus.out_valid && bus.out_ready) begin
            got = {bus.out_src, bus.out_last, bus.out_data};
            exp = sb.size() > 0 ? sb.pop_front() : 10'bx;
            chk("out_flit", 32'(got), 32'(exp));
            out_cyc.push_back(cyc);
        end
        if (blk0) chk("in0_blocked", 32'(bus.in0_ready), 32'd0);
        f0 = bus.in0_valid && bus.in0_ready;
        f1 = bus.in1_valid && bus.in1_ready;
        fw = bus.win_valid && bus.win_ready;
        @(posedge clk);
        #1;
        if (f0) begin
            void'(q0.pop_front());
            n0++;
        end
        if (f1) void'(q1.pop_front());
        if (fw) void'(wq.pop_front());
        if (lenchk) chk("len_err_step", 32'(bus.len_err), 32'(n0 >= 4));
        drive();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || wq.size() != 0) && n < 60) begin
            tick();
            n++;
        end
        chk({tag, "_drain"}, 32'(sb.size()), 32'd0);
        tick();
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        drive();
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_len_err", 32'(bus.len_err), 32'd0);
        chk("rst_win_ready", 32'(bus.win_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rel_in0_ready", 32'(bus.in0_ready), 32'd0);
        chk("rel_in1_ready", 32'(bus.in1_ready), 32'd0);
        tick();

        // three-flit packet on input 0
        out_cyc.delete();
        wq.push_back(1'b0);
        add(1'b0, 1'b0, 8'h11);
        add(1'b0, 1'b0, 8'h22);
        add(1'b0, 1'b1, 8'h33);
        drive();
        drain("pkt3");
        chk("pkt3_count", 32'(out_cyc.size()), 32'd3);
        if (out_cyc.size() == 3) chk("pkt3_consec", 32'(out_cyc[2] - out_cyc[0]), 32'd2);
        chk("pkt3_idle", 32'(bus.win_ready), 32'd1);
        chk("pkt3_outv", 32'(bus.out_valid), 32'd0);

        // grant to input 1 while input 0 also offers a flit
        wq.push_back(1'b1);
        q0.push_back({1'b1, 8'hEE});
        add(1'b1, 1'b0, 8'h55);
        add(1'b1, 1'b1, 8'h66);
        blk0 = 1'b1;
        drive();
        drain("win1");
        blk0 = 1'b0;
        chk("win1_in0_kept", 32'(q0.size()), 32'd1);
        q0.delete();
        drive();
        tick();

        // back-to-back single-flit packets, no bubble
        out_cyc.delete();
        wq.push_back(1'b0);
        wq.push_back(1'b1);
        add(1'b0, 1'b1, 8'hA0);
        add(1'b1, 1'b1, 8'hB1);
        drive();
        drain("b2b");
        chk("b2b_count", 32'(out_cyc.size()), 32'd2);
        if (out_cyc.size() == 2) chk("b2b_consec", 32'(out_cyc[1] - out_cyc[0]), 32'd1);

        // output stall mid-packet
        wq.push_back(1'b0);
        add(1'b0, 1'b0, 8'h01);
        add(1'b0, 1'b0, 8'h02);
        add(1'b0, 1'b0, 8'h03);
        add(1'b0, 1'b1, 8'h04);
        drive();
        repeat (3) tick();
        bus.out_ready = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_hold", 32'({bus.out_src, bus.out_last, bus.out_data}), 32'(sb[0]));
            chk("stall_in0_ready", 32'(bus.in0_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        drain("stall");
        chk("stall_no_err", 32'(bus.len_err), 32'd0);

        // five flits with MAXLEN = 4
        n0 = 0;
        lenchk = 1'b1;
        wq.push_back(1'b0);
        for (int i = 0; i < 5; i++) add(1'b0, i == 4, 8'(8'h40 + i));
        drive();
        drain("len5");
        lenchk = 1'b0;
        repeat (3) tick();
        chk("len_err_sticky", 32'(bus.len_err), 32'd1);

        // reset mid-packet after the second flit
        n0 = 0;
        wq.push_back(1'b0);
        add(1'b0, 1'b0, 8'h71);
        add(1'b0, 1'b0, 8'h72);
        add(1'b0, 1'b0, 8'h73);
        add(1'b0, 1'b1, 8'h74);
        drive();
        for (int k = 0; k < 20 && n0 < 2; k++) tick();
        chk("mid_outv_pre", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outv", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_data", 32'(bus.out_data), 32'd0);
        chk("mid_rst_idle", 32'(bus.win_ready), 32'd1);
        chk("mid_rst_in0r", 32'(bus.in0_ready), 32'd0);
        chk("mid_rst_len", 32'(bus.len_err), 32'd0);
        q0.delete();
        wq.delete();
        sb.delete();
        q0.push_back({1'b0, 8'hC0});
        q1.push_back({1'b0, 8'hC1});
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rel2_in0_ready", 32'(bus.in0_ready), 32'd0);
        chk("rel2_in1_ready", 32'(bus.in1_ready), 32'd0);
        chk("rel2_outv", 32'(bus.out_valid), 32'd0);
        chk("rel2_win_ready", 32'(bus.win_ready), 32'd1);
        tick();
        q0.delete();
        q1.delete();
        wq.push_back(1'b1);
        add(1'b1, 1'b0, 8'h91);
        add(1'b1, 1'b1, 8'h92);
        drive();
        drain("post_rst");
        chk("post_rst_idle", 32'(bus.win_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
